sample_sequencer: RTL and testbench
===================================

// Module: sample_sequencer
// PURPOSE
// Sits directly upstream and downstream of dsp_pipeline: buffers ADC samples in a small FIFO,
// issues them one at a time on the pipeline's in_sample/in_valid/ready handshake, and captures
// out_sample when the pipeline returns to ready. Presents the processed sample to the DAC side.
// Adds bypass, overrun accounting and a watchdog that mutes output if the pipeline stalls.
// PARAMETERS
// data_width      16    sample width (signed two's complement)
// fifo_depth      4     input FIFO entries; power of two, >= 2
// timeout_cycles  4096  watchdog limit, in clk cycles, for one pipeline round trip
// PORTS
// clk              in   1           system clock
// reset            in   1           asynchronous, active-high reset
// adc_sample       in   data_width  incoming sample
// adc_valid        in   1           one-cycle strobe per sample period
// bypass           in   1           1 = route ADC straight to DAC, pipeline not used
// clear_status     in   1           synchronous clear of overrun, timeout and overrun_count
// pipe_in_sample   out  data_width  to dsp_pipeline in_sample
// pipe_in_valid    out  1           to dsp_pipeline in_valid; one-cycle pulse
// pipe_ready       in   1           from dsp_pipeline ready
// pipe_out_sample  in   data_width  from dsp_pipeline out_sample
// dac_sample       out  data_width  processed sample, held until the next dac_valid
// dac_valid        out  1           one-cycle strobe per delivered sample
// fifo_level       out  clog2(fifo_depth)+1  current FIFO occupancy
// overrun          out  1           sticky: a sample was dropped because the FIFO was full
// overrun_count    out  16          dropped samples, saturating at 16'hFFFF
// timeout          out  1           sticky: watchdog fired
// BEHAVIOUR
// - Reset (async): all outputs 0; FIFO empty; state IDLE; watchdog counter 0.
// - All outputs are registered.
// - FIFO push: on adc_valid, when level < fifo_depth OR a pop occurs in the same cycle.
// - Otherwise the new sample is dropped (oldest data is kept); overrun <= 1; overrun_count +1, saturating.
// - Simultaneous push and pop: level is unchanged. Read and write pointers wrap modulo fifo_depth.
// - FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
// - IDLE, bypass=0, level>0 and pipe_ready=1:
//     pop the head; pipe_in_sample <= head; pipe_in_valid <= 1 for one cycle; go to WAIT_BUSY.
// - WAIT_BUSY: pipe_ready=0 -> go to WAIT_DONE. This covers the pipeline's one-cycle ready drop lag.
// - WAIT_DONE: pipe_ready=1 -> dac_sample <= pipe_out_sample; dac_valid <= 1; go to IDLE.
// - Watchdog: counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY and WAIT_DONE.
//   When it reaches timeout_cycles: timeout <= 1; dac_sample <= 0; dac_valid <= 1; go to IDLE.
// - Bypass is sampled only in IDLE, so a transaction in flight always completes.
// - With bypass=1 in IDLE: pop each head and set dac_sample <= head, dac_valid <= 1.
//   pipe_in_valid stays 0.
// - Latency, pipeline path: adc_valid in cycle t with an empty FIFO and pipe_ready=1 -> pipe_in_valid
//   high in cycle t+2. dac_valid is high in the cycle after pipe_ready is seen high in WAIT_DONE.
// - Latency, bypass path: dac_valid in cycle t+2.
// - pipe_in_valid is never asserted in any state other than the IDLE->WAIT_BUSY transition.
// - At most one sample is outstanding in the pipeline.
// - clear_status has priority over a same-cycle overrun increment (result is 0).
//   It does not affect the FIFO or the FSM.
// - Reset mid-transaction: everything returns to reset values; the in-flight sample is discarded.
// TESTING
// 1. Single sample 16'h1234, pipeline model echoes x2 after 10 cycles -> pipe_in_valid at t+2 carrying 16'h1234.
//    Exactly one dac_valid follows, with dac_sample = 16'h2468.
// 2. Five adc_valid back-to-back with fifo_depth=4 and the pipeline stalled (ready held 0 after the first issue).
//    Required: one dropped sample, overrun=1, overrun_count=1, fifo_level=4.
// 3. Ready never returns after issue, timeout_cycles=16 -> timeout=1 and dac_valid with dac_sample=0
//    17 cycles after WAIT_BUSY entry. The next FIFO sample is then issued.
// 4. bypass=1, sample 16'h8001 -> dac_sample=16'h8001 at t+2; pipe_in_valid stays 0.
//    Toggle bypass during WAIT_DONE -> the in-flight result is still delivered from the pipeline.
// 5. Push while full with a same-cycle pop -> sample accepted, no overrun, level stays 4.
//    overrun_count preset to 16'hFFFF, then another drop -> count stays at 16'hFFFF.
// 6. Assert reset asynchronously in WAIT_DONE -> outputs 0 immediately, fifo_level=0.
//    No dac_valid follows after reset is released.

Source files
------------

// File: rtl/sample_sequencer.sv
// sample_sequencer: buffers ADC samples and issues them one at a time to dsp_pipeline,
// with a bypass path, overrun accounting and a round-trip watchdog.
module sample_sequencer #(
    parameter int data_width     = 16,
    parameter int fifo_depth     = 4,
    parameter int timeout_cycles = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [data_width-1:0]       adc_sample,
    input  logic                        adc_valid,
    input  logic                        bypass,
    input  logic                        clear_status,
    output logic [data_width-1:0]       pipe_in_sample,
    output logic                        pipe_in_valid,
    input  logic                        pipe_ready,
    input  logic [data_width-1:0]       pipe_out_sample,
    output logic [data_width-1:0]       dac_sample,
    output logic                        dac_valid,
    output logic [$clog2(fifo_depth):0] fifo_level,
    output logic                        overrun,
    output logic [15:0]                 overrun_count,
    output logic                        timeout
);
    localparam int AW = $clog2(fifo_depth);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(timeout_cycles + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e                state_q, state_d;
    logic [data_width-1:0] mem_q [fifo_depth];
    logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [CW-1:0]         wd_q, wd_d;
    logic [data_width-1:0] pipe_sample_q, pipe_sample_d;
    logic                  pipe_valid_q, pipe_valid_d;
    logic [data_width-1:0] dac_sample_q, dac_sample_d;
    logic                  dac_valid_q, dac_valid_d;
    logic                  overrun_q, overrun_d;
    logic [15:0]           ocount_q, ocount_d;
    logic                  timeout_q, timeout_d;
    logic                  pop, push, drop;
    logic [data_width-1:0] head;

    assign head = mem_q[rd_ptr_q];

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push = adc_valid && ((level_q != LW'(fifo_depth)) || pop);
    assign drop = adc_valid && !push;

    always_comb begin
        state_d       = state_q;
        pipe_sample_d = pipe_sample_q;
        pipe_valid_d  = 1'b0;
        dac_sample_d  = dac_sample_q;
        dac_valid_d   = 1'b0;
        wd_d          = wd_q;
        timeout_d     = timeout_q;
        pop           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    if (bypass) begin
                        pop          = 1'b1;
                        dac_sample_d = head;
                        dac_valid_d  = 1'b1;
                    end else if (pipe_ready) begin
                        pop           = 1'b1;
                        pipe_sample_d = head;
                        pipe_valid_d  = 1'b1;
                        wd_d          = '0;
                        state_d       = WAIT_BUSY;
                    end
                end
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (wd_q == CW'(timeout_cycles)) begin
                    timeout_d    = 1'b1;
                    dac_sample_d = '0;
                    dac_valid_d  = 1'b1;
                    state_d      = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (state_q == WAIT_BUSY) begin
                        if (!pipe_ready) state_d = WAIT_DONE;
                    end else if (pipe_ready) begin
                        dac_sample_d = pipe_out_sample;
                        dac_valid_d  = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        overrun_d = overrun_q | drop;
        ocount_d  = ocount_q;
        if (drop && ocount_q != 16'hFFFF) ocount_d = ocount_q + 16'd1;
        if (clear_status) begin
            overrun_d = 1'b0;
            ocount_d  = '0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= adc_sample;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            level_q       <= '0;
            wd_q          <= '0;
            pipe_sample_q <= '0;
            pipe_valid_q  <= 1'b0;
            dac_sample_q  <= '0;
            dac_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            ocount_q      <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            level_q       <= level_d;
            wd_q          <= wd_d;
            pipe_sample_q <= pipe_sample_d;
            pipe_valid_q  <= pipe_valid_d;
            dac_sample_q  <= dac_sample_d;
            dac_valid_q   <= dac_valid_d;
            overrun_q     <= overrun_d;
            ocount_q      <= ocount_d;
            timeout_q     <= timeout_d;
        end
    end

    assign pipe_in_sample = pipe_sample_q;
    assign pipe_in_valid  = pipe_valid_q;
    assign dac_sample     = dac_sample_q;
    assign dac_valid      = dac_valid_q;
    assign fifo_level     = level_q;
    assign overrun        = overrun_q;
    assign overrun_count  = ocount_q;
    assign timeout        = timeout_q;
endmodule

// File: tb/tb_sample_sequencer.sv
// Scoreboard bench for sample_sequencer with a behavioural dsp_pipeline
// that echoes x2 after 10 cycles, or hangs on request.
module tb_sample_sequencer;
    localparam int DW  = 16;
    localparam int DEP = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] adc_sample;
    logic          adc_valid;
    logic          bypass;
    logic          clear_status;
    logic [DW-1:0] pipe_in_sample;
    logic          pipe_in_valid;
    logic          pipe_ready;
    logic [DW-1:0] pipe_out_sample;
    logic [DW-1:0] dac_sample;
    logic          dac_valid;
    logic [2:0]    fifo_level;
    logic          overrun;
    logic [15:0]   overrun_count;
    logic          timeout;

    sample_sequencer #(
        .data_width(DW),
        .fifo_depth(DEP),
        .timeout_cycles(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .adc_sample(adc_sample),
        .adc_valid(adc_valid),
        .bypass(bypass),
        .clear_status(clear_status),
        .pipe_in_sample(pipe_in_sample),
        .pipe_in_valid(pipe_in_valid),
        .pipe_ready(pipe_ready),
        .pipe_out_sample(pipe_out_sample),
        .dac_sample(dac_sample),
        .dac_valid(dac_valid),
        .fifo_level(fifo_level),
        .overrun(overrun),
        .overrun_count(overrun_count),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t pipe_q[$];
    exp_t dac_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   pipe_hang = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_pipe(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        pipe_q.push_back(e);
    endtask

    task automatic exp_dac(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        dac_q.push_back(e);
    endtask

    // Monitor: every presented output must match the head of its queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pipe_in_valid) begin
                    check("pipe_expected", 32'(pipe_q.size() != 0), 1);
                    if (pipe_q.size() != 0) begin
                        e = pipe_q.pop_front();
                        check("pipe_data", pipe_in_sample, e.data);
                        if (e.cyc >= 0) check("pipe_cycle", cyc, e.cyc);
                    end
                end
                if (dac_valid) begin
                    check("dac_expected", 32'(dac_q.size() != 0), 1);
                    if (dac_q.size() != 0) begin
                        e = dac_q.pop_front();
                        check("dac_data", dac_sample, e.data);
                        if (e.cyc >= 0) check("dac_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Pipeline model: ready drops one cycle after in_valid, result 10 cycles later.
    initial begin
        bit          m_pend;
        int          m_cnt;
        logic [15:0] m_res;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_res  = '0;
        pipe_ready      = 1'b1;
        pipe_out_sample = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_pend     = 1'b0;
                m_cnt      = 0;
                pipe_ready = 1'b1;
            end else if (m_pend) begin
                m_pend     = 1'b0;
                m_cnt      = 10;
                pipe_ready = 1'b0;
            end else if (m_cnt != 0) begin
                if (!pipe_hang) m_cnt--;
                if (m_cnt == 0) begin
                    pipe_out_sample = m_res;
                    pipe_ready      = 1'b1;
                end
            end else if (pipe_in_valid) begin
                m_pend = 1'b1;
                m_res  = pipe_in_sample << 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((pipe_q.size() != 0 || dac_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pipe_q.size() + dac_q.size()), 0);
        pipe_q.delete();
        dac_q.delete();
    endtask

    task automatic wait_issue(input string name, input int max);
        int n = 0;
        while (pipe_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pipe_q.size()), 0);
    endtask

    initial begin
        int t;
        int n;
        reset        = 1'b1;
        adc_valid    = 1'b0;
        adc_sample   = '0;
        bypass       = 1'b0;
        clear_status = 1'b0;
        tick(3);
        check("rst_pipe_valid", pipe_in_valid, 0);
        check("rst_pipe_sample", pipe_in_sample, 0);
        check("rst_dac_valid", dac_valid, 0);
        check("rst_dac_sample", dac_sample, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_count", overrun_count, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        tick(2);

        // Single sample through the pipeline.
        adc_sample = 16'h1234;
        adc_valid  = 1'b1;
        t = cyc;
        exp_pipe(16'h1234, t + 2);
        exp_dac(16'h2468, -1);
        tick(1);
        adc_valid = 1'b0;
        wait_drain("t1_drain", 40);
        tick(15);

        // Stalled pipeline: one issue, five more samples, one dropped, then watchdog.
        pipe_hang  = 1'b1;
        adc_sample = 16'h0A00;
        adc_valid  = 1'b1;
        t = cyc;
        exp_pipe(16'h0A00, t + 2);
        exp_dac(16'h0000, t + 2 + TMO + 1);
        tick(1);
        adc_valid = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            adc_sample = 16'h0B00 + 16'(i);
            adc_valid  = 1'b1;
            tick(1);
        end
        adc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_pipe(16'h0B00 + 16'(i), -1);
            exp_dac(16'h1600 + 16'(2 * i), -1);
        end
        tick(1);
        check("t2_level", fifo_level, 4);
        check("t2_overrun", overrun, 1);
        check("t2_count", overrun_count, 1);
        check("t2_timeout_early", timeout, 0);
        tick(12);
        check("t3_timeout", timeout, 1);
        check("t3_level_held", fifo_level, 4);
        pipe_hang = 1'b0;
        wait_drain("t3_drain", 200);
        check("t3_level_empty", fifo_level, 0);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_count", overrun_count, 0);
        check("clr_timeout", timeout, 0);

        // Bypass path, then bypass toggled while a pipeline result is pending.
        bypass     = 1'b1;
        adc_sample = 16'h8001;
        adc_valid  = 1'b1;
        t = cyc;
        exp_dac(16'h8001, t + 2);
        tick(1);
        adc_valid = 1'b0;
        wait_drain("t4_bypass", 10);
        tick(3);
        bypass     = 1'b0;
        adc_sample = 16'h0010;
        adc_valid  = 1'b1;
        exp_pipe(16'h0010, -1);
        exp_dac(16'h0020, -1);
        tick(1);
        adc_valid = 1'b0;
        wait_issue("t4_issue", 10);
        tick(3);
        bypass = 1'b1;
        wait_drain("t4_inflight", 40);
        bypass = 1'b0;
        tick(3);

        // Full FIFO with a same-cycle pop accepts the new sample.
        for (int i = 0; i < 5; i++) begin
            adc_sample = 16'h0300 + 16'(i);
            adc_valid  = 1'b1;
            exp_pipe(16'h0300 + 16'(i), -1);
            exp_dac(16'h0600 + 16'(2 * i), -1);
            tick(1);
        end
        adc_valid = 1'b0;
        n = 0;
        while (!dac_valid && n < 50) begin
            tick(1);
            n++;
        end
        check("t5_pop_seen", dac_valid, 1);
        check("t5_level_full", fifo_level, 4);
        adc_sample = 16'h0305;
        adc_valid  = 1'b1;
        exp_pipe(16'h0305, -1);
        exp_dac(16'h060A, -1);
        tick(1);
        adc_valid = 1'b0;
        check("t5_level_same", fifo_level, 4);
        check("t5_no_overrun", overrun, 0);
        check("t5_no_count", overrun_count, 0);
        wait_drain("t5_drain", 200);

        // Saturating overrun counter, then clear beating a same-cycle drop.
        pipe_hang  = 1'b1;
        adc_sample = 16'h0700;
        adc_valid  = 1'b1;
        exp_pipe(16'h0700, -1);
        exp_dac(16'h0000, -1);
        tick(1);
        adc_valid = 1'b0;
        tick(1);
        adc_sample = 16'h0701;
        adc_valid  = 1'b1;
        tick(4 + 65535);
        check("t5_count_max", overrun_count, 16'hFFFF);
        check("t5_overrun_set", overrun, 1);
        tick(3);
        check("t5_count_sat", overrun_count, 16'hFFFF);
        check("t5_timeout_set", timeout, 1);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        adc_valid    = 1'b0;
        check("t5_clr_count", overrun_count, 0);
        check("t5_clr_overrun", overrun, 0);
        check("t5_clr_timeout", timeout, 0);
        for (int i = 0; i < 4; i++) begin
            exp_pipe(16'h0701, -1);
            exp_dac(16'h0E02, -1);
        end
        pipe_hang = 1'b0;
        wait_drain("t5_sat_drain", 200);
        tick(3);

        // Asynchronous reset while waiting for the pipeline result.
        adc_sample = 16'h0055;
        adc_valid  = 1'b1;
        exp_pipe(16'h0055, -1);
        tick(1);
        adc_valid = 1'b0;
        wait_issue("t6_issue", 10);
        tick(4);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_dac_sample", dac_sample, 0);
        check("t6_dac_valid", dac_valid, 0);
        check("t6_pipe_sample", pipe_in_sample, 0);
        check("t6_level", fifo_level, 0);
        tick(2);
        reset = 1'b0;
        tick(30);
        check("t6_level_after", fifo_level, 0);
        check("final_queues", 32'(pipe_q.size() + dac_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
